cic_decim_ctrl: RTL and testbench
=================================

CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 The block SHALL expose parameter STAGES, default 4, meaning the number of CIC integrator/comb stages (the priming depth).
REQ-002 The block SHALL expose parameter RATIO_W, default 8, meaning the width of the decimation-ratio input.
REQ-003 The block SHALL expose parameter CNT_W, default 16, meaning the width of the output-sample counter.
REQ-004 The block SHALL provide port `clock`, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-005 The block SHALL provide port `reset`, input, 1 bit: asynchronous, active-low reset (asserted when 0).
REQ-006 The block SHALL provide port `start`, input, 1 bit: single-cycle request to begin a decimation run.
REQ-007 The block SHALL provide port `stop`, input, 1 bit: single-cycle request to abort the run and return to IDLE.
REQ-008 The block SHALL provide port `cfg_ratio`, input, RATIO_W bits: decimation ratio R, sampled only when `start` is accepted.
REQ-009 The block SHALL provide ports `in_valid` (input, 1 bit) and `in_ready` (output, 1 bit): the input-sample handshake.
REQ-010 The block SHALL provide port `integ_en`, output, 1 bit: enable for the integrator section.
REQ-011 The block SHALL provide port `comb_en`, output, 1 bit: enable for the comb section and the decimated-sample capture.
REQ-012 The block SHALL provide port `clr_pipe`, output, 1 bit: synchronous clear for all filter registers.
REQ-013 The block SHALL provide ports `out_valid` (output, 1 bit) and `out_ready` (input, 1 bit): the decimated-output handshake.
REQ-014 The block SHALL provide port `state`, output, 2 bits: current FSM state encoding.
REQ-015 The block SHALL provide port `sample_cnt`, output, CNT_W bits: count of delivered output samples.

Function
REQ-016 The FSM SHALL have states IDLE=00, CLEAR=01, PRIME=10 and RUN=11.
REQ-017 From IDLE, `start`=1 with `stop`=0 SHALL latch R and move the FSM to CLEAR; R_eff = 1 when `cfg_ratio` is 0, otherwise R_eff = `cfg_ratio`.
REQ-018 CLEAR SHALL last exactly one cycle with `clr_pipe`=1, SHALL reset the phase, prime and sample counters to 0, and SHALL then move to PRIME.
REQ-019 `in_ready` SHALL be 0 in IDLE and CLEAR.
REQ-020 In PRIME and RUN, `in_ready` SHALL be 0 only when `out_valid`=1, `out_ready`=0 and phase = R_eff-1; otherwise it SHALL be 1.
REQ-021 An input sample is accepted when `in_valid` and `in_ready` are both 1 in PRIME or RUN; this condition is called accept.
REQ-022 `integ_en` SHALL equal accept, combinationally.
REQ-023 `comb_en` SHALL equal accept AND (phase = R_eff-1), combinationally.
REQ-024 On each accept, phase SHALL increment and wrap to 0 after R_eff-1; with R_eff=1, every accept SHALL raise `comb_en`.
REQ-025 In PRIME, each `comb_en` SHALL increment the prime counter and SHALL NOT raise `out_valid`; the `comb_en` that brings the prime counter to STAGES SHALL move the FSM to RUN on the same edge.
REQ-026 In RUN, `comb_en` SHALL set `out_valid` on the next edge, giving one cycle of latency.
REQ-027 `out_valid` SHALL be held until `out_valid`=1 and `out_ready`=1 on the same edge, which clears it and increments `sample_cnt` with modulo-2^CNT_W wrap.
REQ-028 If a handshake and `comb_en` occur on the same edge, `out_valid` SHALL remain 1 and `sample_cnt` SHALL still increment.
REQ-029 In any state other than IDLE, `stop`=1 SHALL return the FSM to IDLE on the next edge, clear `out_valid` and phase, and hold `sample_cnt`; `stop` SHALL take priority over `start` and over any handshake in the same cycle.
REQ-030 `start` outside IDLE SHALL be ignored; `cfg_ratio` changes outside an accepted `start` SHALL have no effect.

Reset
REQ-031 While `reset`=0, regardless of `clock`, the block SHALL hold state=IDLE, `out_valid`=0, `clr_pipe`=0, `in_ready`=0, `integ_en`=0, `comb_en`=0, `sample_cnt`=0, and phase and prime counters at 0.
REQ-032 Reset asserted mid-run SHALL abandon the run, and the block SHALL restart only on a new `start`.

Verification
REQ-033 Basic run: reset, start with `cfg_ratio`=4, `in_valid`=1 and `out_ready`=1 constantly -> `clr_pipe` for 1 cycle, the first 4 `comb_en` (every 4th accept) produce no `out_valid`, `out_valid` begins one cycle after the 5th `comb_en`, and `sample_cnt`=10 after 14 `comb_en`.
REQ-034 Backpressure: in RUN with `out_ready`=0 -> `out_valid` stays 1, `in_ready`=0 only at phase 3, no `comb_en` is lost; releasing `out_ready` restarts accepts.
REQ-035 Ratio edges: `cfg_ratio`=0 and `cfg_ratio`=1 -> `comb_en`=`integ_en` every accept; `cfg_ratio`=255 -> `comb_en` once per 255 accepts.
REQ-036 Stop and start together mid-PRIME -> IDLE next edge, `out_valid`=0, `sample_cnt` unchanged.
REQ-037 Asynchronous `reset` pulse between clock edges during RUN -> all outputs reach reset values immediately, without waiting for a clock edge.
REQ-038 `sample_cnt` wrap: with CNT_W=4, 17 deliveries -> `sample_cnt`=1.

Source files
------------

// File: rtl/cic_decim_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : cic_decim_ctrl
// Brief   : Clear/prime/run sequencer and in/out handshakes for a CIC decimator.
// Revision: 1.0 - initial release
// ============================================================================
module cic_decim_ctrl #(
    parameter int STAGES  = 4,
    parameter int RATIO_W = 8,
    parameter int CNT_W   = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               stop,
    input  logic [RATIO_W-1:0] cfg_ratio,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               integ_en,
    output logic               comb_en,
    output logic               clr_pipe,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   sample_cnt
);

    localparam int                   C_PRIME_W    = $clog2(STAGES + 1);
    localparam logic [C_PRIME_W-1:0] C_PRIME_LAST = C_PRIME_W'(STAGES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CLEAR = 2'b01,
        ST_PRIME = 2'b10,
        ST_RUN   = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [RATIO_W-1:0]   r_ratio_m1;
    logic [RATIO_W-1:0]   r_phase;
    logic [C_PRIME_W-1:0] r_prime_cnt;
    logic                 r_out_valid;
    logic [CNT_W-1:0]     r_sample_cnt;

    logic w_active;
    logic w_last_phase;
    logic w_abort;
    logic w_in_ready;
    logic w_accept;
    logic w_comb;
    logic w_handshake;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_active     = (r_state == ST_PRIME) || (r_state == ST_RUN);
        w_last_phase = (r_phase == r_ratio_m1);
        w_abort      = stop && (r_state != ST_IDLE);
        // Only stall input when the sample about to be decimated has nowhere to go.
        w_in_ready   = w_active && !(r_out_valid && !out_ready && w_last_phase);
        w_accept     = in_valid && w_in_ready;
        w_comb       = w_accept && w_last_phase;
        w_handshake  = r_out_valid && out_ready;
        case (r_state)
            ST_IDLE:  if (start && !stop) w_state_nxt = ST_CLEAR;
            ST_CLEAR: w_state_nxt = ST_PRIME;
            ST_PRIME: if (w_comb && (r_prime_cnt == C_PRIME_LAST)) w_state_nxt = ST_RUN;
            default:  w_state_nxt = r_state;
        endcase
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_ratio_m1   <= '0;
            r_phase      <= '0;
            r_prime_cnt  <= '0;
            r_out_valid  <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            // A ratio of zero behaves as one.
            if ((r_state == ST_IDLE) && start && !stop)
                r_ratio_m1 <= (cfg_ratio == '0) ? '0 : cfg_ratio - RATIO_W'(1);

            if (w_abort || (r_state == ST_CLEAR))
                r_phase <= '0;
            else if (w_accept)
                r_phase <= w_last_phase ? '0 : r_phase + RATIO_W'(1);

            if (r_state == ST_CLEAR)
                r_prime_cnt <= '0;
            else if ((r_state == ST_PRIME) && w_comb)
                r_prime_cnt <= r_prime_cnt + C_PRIME_W'(1);

            if (w_abort)
                r_out_valid <= 1'b0;
            else if ((r_state == ST_RUN) && w_comb)
                r_out_valid <= 1'b1;
            else if (w_handshake)
                r_out_valid <= 1'b0;

            if (r_state == ST_CLEAR)
                r_sample_cnt <= '0;
            else if (w_handshake && !w_abort)
                r_sample_cnt <= r_sample_cnt + CNT_W'(1);
        end
    end

    assign in_ready   = w_in_ready;
    assign integ_en   = w_accept;
    assign comb_en    = w_comb;
    assign clr_pipe   = (r_state == ST_CLEAR);
    assign out_valid  = r_out_valid;
    assign state      = r_state;
    assign sample_cnt = r_sample_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cic_decim_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_cic_decim_ctrl
// Brief   : Directed vector bench for cic_decim_ctrl (STAGES=4, RATIO_W=8, CNT_W=4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cic_decim_ctrl;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       start     = 1'b0;
    logic       stop      = 1'b0;
    logic [7:0] cfg_ratio = 8'd0;
    logic       in_valid  = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready;
    logic       integ_en;
    logic       comb_en;
    logic       clr_pipe;
    logic       out_valid;
    logic [1:0] state;
    logic [3:0] sample_cnt;

    int n_vec = 0;
    int n_bad = 0;

    cic_decim_ctrl #(
        .STAGES (4),
        .RATIO_W(8),
        .CNT_W  (4)
    ) u_dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .stop      (stop),
        .cfg_ratio (cfg_ratio),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .integ_en  (integ_en),
        .comb_en   (comb_en),
        .clr_pipe  (clr_pipe),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state     (state),
        .sample_cnt(sample_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        st;
        logic        sp;
        logic [7:0]  r;
        logic        iv;
        logic        ordy;
        logic [10:0] expv;
    } vec_t;

    // Packed outputs: {state, in_ready, integ_en, comb_en, clr_pipe, out_valid, sample_cnt}
    function automatic logic [10:0] pk(input logic [1:0] st, input logic ir, input logic ig,
                                       input logic cb, input logic cl, input logic ov,
                                       input logic [3:0] cnt);
        return {st, ir, ig, cb, cl, ov, cnt};
    endfunction

    task automatic drive(input logic st, input logic sp, input logic [7:0] r,
                         input logic iv, input logic ordy);
        start = st; stop = sp; cfg_ratio = r; in_valid = iv; out_ready = ordy;
    endtask

    task automatic check(input string name, input logic [10:0] expv);
        logic [10:0] got;
        got = {state, in_ready, integ_en, comb_en, clr_pipe, out_valid, sample_cnt};
        n_vec++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got st/ir/ig/cb/cl/ov/cnt=%b expected %b", name, got, expv);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int expv);
        n_vec++;
        if (got != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, expv);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic apply(input string name, input logic st, input logic sp, input logic [7:0] r,
                         input logic iv, input logic ordy, input logic [10:0] expv);
        drive(st, sp, r, iv, ordy);
        #1;
        check(name, expv);
        step();
    endtask

    vec_t tbl[15];

    initial begin
        int n_acc, n_comb, exp_cnt;
        logic exp_cb, prev_fire;

        // Ratio 0 (acts as 1): clear, four primes, run, backpressure, ignored start, stop vs handshake.
        tbl[0]  = '{1'b1, 1'b0, 8'd0, 1'b1, 1'b1, pk(2'd0, 0, 0, 0, 0, 0, 4'd0)};
        tbl[1]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, pk(2'd1, 0, 0, 0, 1, 0, 4'd0)};
        tbl[2]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, pk(2'd2, 1, 1, 1, 0, 0, 4'd0)};
        tbl[3]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, pk(2'd2, 1, 1, 1, 0, 0, 4'd0)};
        tbl[4]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, pk(2'd2, 1, 1, 1, 0, 0, 4'd0)};
        tbl[5]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, pk(2'd2, 1, 1, 1, 0, 0, 4'd0)};
        tbl[6]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, pk(2'd3, 1, 1, 1, 0, 0, 4'd0)};
        tbl[7]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, pk(2'd3, 1, 1, 1, 0, 1, 4'd0)};
        tbl[8]  = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, pk(2'd3, 0, 0, 0, 0, 1, 4'd1)};
        tbl[9]  = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b0, pk(2'd3, 0, 0, 0, 0, 1, 4'd1)};
        tbl[10] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b1, pk(2'd3, 1, 0, 0, 0, 1, 4'd1)};
        tbl[11] = '{1'b0, 1'b0, 8'd0, 1'b0, 1'b0, pk(2'd3, 1, 0, 0, 0, 0, 4'd2)};
        tbl[12] = '{1'b1, 1'b0, 8'd5, 1'b1, 1'b1, pk(2'd3, 1, 1, 1, 0, 0, 4'd2)};
        tbl[13] = '{1'b0, 1'b1, 8'd0, 1'b0, 1'b1, pk(2'd3, 1, 0, 0, 0, 1, 4'd2)};
        tbl[14] = '{1'b0, 1'b0, 8'd0, 1'b1, 1'b1, pk(2'd0, 0, 0, 0, 0, 0, 4'd2)};

        // Reset held across clock edges.
        drive(0, 0, 8'd0, 1, 1);
        @(negedge clock);
        @(negedge clock);
        check("reset_hold", pk(2'd0, 0, 0, 0, 0, 0, 4'd0));
        reset = 1'b1;

        for (int i = 0; i < 15; i++)
            apply($sformatf("tbl[%0d]", i), tbl[i].st, tbl[i].sp, tbl[i].r,
                  tbl[i].iv, tbl[i].ordy, tbl[i].expv);

        // Basic run with R=4 and no backpressure.
        apply("basic_idle", 1, 0, 8'd4, 1, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd2));
        apply("basic_clear", 0, 0, 8'd9, 1, 1, pk(2'd1, 0, 0, 0, 1, 0, 4'd2));
        n_acc = 0; n_comb = 0; exp_cnt = 0; prev_fire = 1'b0;
        for (int cyc = 0; cyc < 100 && n_comb < 14; cyc++) begin
            exp_cb = ((n_acc % 4) == 3);
            apply($sformatf("basic_cyc%0d", cyc), 0, 0, 8'd9, 1, 1,
                  pk((n_comb < 4) ? 2'd2 : 2'd3, 1, 1, exp_cb, 0, prev_fire, 4'(exp_cnt)));
            if (prev_fire) exp_cnt++;
            n_acc++;
            if (exp_cb) begin
                n_comb++;
                prev_fire = (n_comb >= 5);
            end else begin
                prev_fire = 1'b0;
            end
        end
        chk_int("basic_comb_count", n_comb, 14);
        apply("basic_last_ov", 0, 0, 8'd0, 0, 1, pk(2'd3, 1, 0, 0, 0, 1, 4'd9));
        apply("basic_cnt10", 0, 0, 8'd0, 0, 1, pk(2'd3, 1, 0, 0, 0, 0, 4'd10));

        // Backpressure at phase 3 with R=4.
        for (int i = 0; i < 3; i++)
            apply("bp_fill", 0, 0, 8'd0, 1, 0, pk(2'd3, 1, 1, 0, 0, 0, 4'd10));
        apply("bp_comb", 0, 0, 8'd0, 1, 0, pk(2'd3, 1, 1, 1, 0, 0, 4'd10));
        for (int i = 0; i < 3; i++)
            apply("bp_accept", 0, 0, 8'd0, 1, 0, pk(2'd3, 1, 1, 0, 0, 1, 4'd10));
        for (int i = 0; i < 3; i++)
            apply("bp_stall", 0, 0, 8'd0, 1, 0, pk(2'd3, 0, 0, 0, 0, 1, 4'd10));
        apply("bp_release", 0, 0, 8'd0, 1, 1, pk(2'd3, 1, 1, 1, 0, 1, 4'd10));
        apply("bp_hs_comb", 0, 0, 8'd0, 0, 1, pk(2'd3, 1, 0, 0, 0, 1, 4'd11));
        apply("bp_drain", 0, 0, 8'd0, 0, 1, pk(2'd3, 1, 0, 0, 0, 0, 4'd12));
        apply("bp_stop", 0, 1, 8'd0, 0, 1, pk(2'd3, 1, 0, 0, 0, 0, 4'd12));
        apply("bp_idle", 0, 0, 8'd0, 0, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd12));

        // R=1: every accept decimates.
        apply("r1_start", 1, 0, 8'd1, 1, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd12));
        apply("r1_clear", 0, 0, 8'd1, 1, 1, pk(2'd1, 0, 0, 0, 1, 0, 4'd12));
        for (int i = 0; i < 4; i++)
            apply("r1_prime", 0, 0, 8'd1, 1, 1, pk(2'd2, 1, 1, 1, 0, 0, 4'd0));
        apply("r1_stop", 0, 1, 8'd1, 1, 1, pk(2'd3, 1, 1, 1, 0, 0, 4'd0));
        apply("r1_idle", 0, 0, 8'd1, 0, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd0));

        // R=255: one comb per 255 accepts, still priming after two.
        apply("r255_start", 1, 0, 8'd255, 1, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd0));
        apply("r255_clear", 0, 0, 8'd3, 1, 1, pk(2'd1, 0, 0, 0, 1, 0, 4'd0));
        for (int i = 0; i < 510; i++)
            apply($sformatf("r255_acc%0d", i), 0, 0, 8'd3, 1, 1,
                  pk(2'd2, 1, 1, ((i % 255) == 254), 0, 0, 4'd0));

        // Stop together with start in PRIME.
        apply("ss_prime", 1, 1, 8'd2, 1, 1, pk(2'd2, 1, 1, 0, 0, 0, 4'd0));
        apply("ss_idle", 0, 0, 8'd2, 0, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd0));
        apply("ss_stay", 0, 0, 8'd2, 1, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd0));

        // Counter wrap at 4 bits: 17 deliveries leave 1.
        apply("wrap_start", 1, 0, 8'd1, 1, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd0));
        apply("wrap_clear", 0, 0, 8'd1, 1, 1, pk(2'd1, 0, 0, 0, 1, 0, 4'd0));
        for (int i = 0; i < 4; i++)
            apply("wrap_prime", 0, 0, 8'd1, 1, 1, pk(2'd2, 1, 1, 1, 0, 0, 4'd0));
        for (int k = 0; k < 19; k++)
            apply($sformatf("wrap_run%0d", k), 0, 0, 8'd1, 1, 1,
                  pk(2'd3, 1, 1, 1, 0, (k >= 1), 4'((k >= 2) ? k - 1 : 0)));

        // Asynchronous reset between edges while running.
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset", pk(2'd0, 0, 0, 0, 0, 0, 4'd0));
        step();
        step();
        reset = 1'b1;
        apply("rst_no_restart", 0, 0, 8'd2, 1, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd0));
        apply("rst_restart", 1, 0, 8'd2, 1, 1, pk(2'd0, 0, 0, 0, 0, 0, 4'd0));
        apply("rst_clear", 0, 0, 8'd2, 1, 1, pk(2'd1, 0, 0, 0, 1, 0, 4'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
